mdu_ctrl: RTL and testbench

Multiply/divide unit controller that owns the HI/LO register pair of the five-stage MIPS pipeline. It accepts HI/LO-class operations issued from EX and runs multi-cycle multiply/divide sequences. It commits results to HI/LO and raises a stall request while any decode-stage instruction that touches HI/LO would observe a stale value. Its `hi`/`lo` outputs are the architectural HI/LO values that feed the MEM/WB pipeline registers and the decode-stage forwarding muxes.

---
 rtl/mdu_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: HI/LO owner and multiply/divide sequencer for the MIPS pipeline.
// Multi-cycle ops latch their operands, count down a latency counter, then
// commit to HI/LO in one step and pulse done. MTHI/MTLO write HI/LO directly.
// Build option: define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU; when it is
// undefined those codes behave as no-ops and the accumulate adder is not built.
`timescale 1ns/1ps

module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  // Counter is loaded with N-1 so that busy lasts exactly N cycles.
  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  // Decode of the incoming EX-stage op
  logic in_is_mul, in_is_div, in_is_acc, in_multi;
  assign in_is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign in_is_div = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
  assign in_is_acc = (op == OP_MADD) || (op == OP_MADDU) ||
                     (op == OP_MSUB) || (op == OP_MSUBU);
`else
  assign in_is_acc = 1'b0;
`endif
  assign in_multi = in_is_mul || in_is_div || in_is_acc;

  // Multiplier: operands extended to 64 bits so one unsigned multiply
  // yields the correct low 64 bits for both signed and unsigned forms.
  logic        mul_signed;
  logic [63:0] mul_a, mul_b, product;
`ifdef MDU_MADD_EN
  assign mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
`else
  assign mul_signed = (op_q == OP_MULT);
`endif
  assign mul_a   = mul_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign mul_b   = mul_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign product = mul_a * mul_b;

  // Divider on magnitudes; signs reapplied afterwards. This also makes
  // 0x80000000 / -1 come out as LO=0x80000000, HI=0 without special-casing.
  logic        div_signed, a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  assign div_signed = (op_q == OP_DIV);
  assign a_neg  = div_signed & a_q[31];
  assign b_neg  = div_signed & b_q[31];
  assign a_mag  = a_neg ? (~a_q + 32'd1) : a_q;
  assign b_mag  = b_neg ? (~b_q + 32'd1) : b_q;
  assign b_zero = (b_q == 32'd0);
  assign q_mag  = b_zero ? 32'd0 : (a_mag / b_mag);
  assign r_mag  = b_zero ? 32'd0 : (a_mag % b_mag);
  assign quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem    = a_neg ? (~r_mag + 32'd1) : r_mag;

  // Value HI/LO take when the running op commits
  logic [31:0] commit_hi, commit_lo;
  always_comb begin
    commit_hi = hi_q;
    commit_lo = lo_q;
    case (op_q)
      OP_MULT, OP_MULTU: {commit_hi, commit_lo} = product;
      OP_DIV, OP_DIVU: begin
        if (!b_zero) begin
          commit_hi = rem;
          commit_lo = quot;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: {commit_hi, commit_lo} = {hi_q, lo_q} + product;
      OP_MSUB, OP_MSUBU: {commit_hi, commit_lo} = {hi_q, lo_q} - product;
`endif
      default: ;
    endcase
  end

  // Next-state logic: accept ops in IDLE, count down and commit in RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (in_multi) begin
            op_d    = op;
            a_d     = rs_val;
            b_d     = rt_val;
            cnt_d   = in_is_div ? DIV_LOAD : MULT_LOAD;
            state_d = S_RUN;
          end else if (op == OP_MTHI) begin
            hi_d = rs_val;
          end else if (op == OP_MTLO) begin
            lo_d = rs_val;
          end
        end
      end
      S_RUN: begin
        // start is ignored here; the hazard unit keeps it low while busy
        if (cnt_q == 5'd0) begin
          hi_d    = commit_hi;
          lo_d    = commit_lo;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and architectural register update; reset discards any in-flight op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q == S_RUN);
  assign stall = md_use & (busy | (start & in_multi));
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench for mdu_ctrl. Expected HI/LO for each
// multi-cycle op is queued at issue and compared when done pulses.
`timescale 1ns/1ps

module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        md_use = 1'b0;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [63:0] sb_q[$];
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .md_use(md_use),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model of the HI/LO result, built on 64-bit integer arithmetic
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] acc;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    acc = {model_hi, model_lo};
    case (o)
      4'd1: return sa * sbv;
      4'd2: return ua * ub;
      4'd3: begin
        if (b == 32'd0) return acc;
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return acc;
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      4'd7:  return acc + 64'(sa * sbv);
      4'd8:  return acc + 64'(ua * ub);
      4'd9:  return acc - 64'(sa * sbv);
      4'd10: return acc - 64'(ua * ub);
      default: return acc;
    endcase
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest queued result
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("done_unexpected", 64'd1, 64'd0);
      end else begin
        check("hilo_commit", {hi, lo}, sb_q.pop_front());
      end
    end
  end

  // Protocol: the hazard unit never issues while the unit is busy
  always @(posedge clk) begin
    if (rst_n && busy && start) check("proto_start_busy", 64'd1, 64'd0);
  end

  task automatic run_multi(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic use_md, input int n);
    logic [63:0] e;
    int busy_cnt;
    int cyc;
    e = model(o, a, b);
    $display("op=%0d rs=%h rt=%h md_use=%0b -> hi=%h lo=%h", o, a, b, use_md, e[63:32], e[31:0]);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b; md_use = use_md;
    #1 check("stall_start", {63'd0, stall}, {63'd0, use_md});
    sb_q.push_back(e);
    model_hi = e[63:32];
    model_lo = e[31:0];
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    busy_cnt = 0;
    cyc = 0;
    while (!done && cyc < 40) begin
      if (busy) begin
        busy_cnt++;
        check("stall_busy", {63'd0, stall}, {63'd0, use_md});
      end
      cyc++;
      @(negedge clk);
    end
    if (!done) check("done_timeout", 64'd0, 64'd1);
    check("busy_cycles", 64'(busy_cnt), 64'(n));
    check("stall_done", {63'd0, stall}, 64'd0);
    @(negedge clk);
    check("done_pulse_once", {63'd0, done}, 64'd0);
    md_use = 1'b0;
  endtask

  // Single-cycle or ignored op: no busy at any point, HI/LO follow the model
  task automatic run_quick(input logic [3:0] o, input logic [31:0] a);
    $display("op=%0d rs=%h (single-cycle)", o, a);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = 32'h5a5a5a5a; md_use = 1'b1;
    #1 check("stall_quick", {63'd0, stall}, 64'd0);
    if (o == 4'd5) model_hi = a;
    if (o == 4'd6) model_lo = a;
    @(negedge clk);
    start = 1'b0; op = 4'd0; md_use = 1'b0;
    check("busy_quick", {63'd0, busy}, 64'd0);
    check("hilo_quick", {hi, lo}, {model_hi, model_lo});
    @(negedge clk);
    check("busy_quick2", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_busy", {62'd0, busy, done}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_stall", {63'd0, stall}, 64'd0);

    run_multi(4'd1, 32'hFFFFFFFD, 32'd7, 1'b1, 5);   // MULT -3*7 with MFLO waiting
    check("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    run_multi(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5);
    run_multi(4'd4, 32'd100, 32'd7, 1'b0, 10);       // DIVU
    check("divu_hilo", {hi, lo}, {32'd2, 32'd14});
    run_multi(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1, 10);  // DIV -7/2
    check("div_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_multi(4'd3, 32'd55, 32'd0, 1'b0, 10);        // divide by zero
    check("div0_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_multi(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10);
    check("div_ovf_hilo", {hi, lo}, {32'd0, 32'h80000000});

    run_quick(4'd5, 32'h12345678);                   // MTHI
    run_quick(4'd6, 32'hCAFEF00D);                   // MTLO
    run_quick(4'd0, 32'h11111111);                   // no-op codes
    run_quick(4'd15, 32'h22222222);

    for (int i = 0; i < 6; i++) begin
      logic [3:0] o;
      o = 4'($urandom_range(1, 4));
      run_multi(o, $urandom, $urandom, 1'($urandom_range(0, 1)), (o >= 4'd3) ? 10 : 5);
    end

    // Asynchronous reset in the third busy cycle of a DIV
    @(negedge clk);
    start = 1'b1; op = 4'd3; rs_val = 32'd1000; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    repeat (2) @(negedge clk);
    check("busy_before_rst", {63'd0, busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    check("rst_mid_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_hi = 32'd0;
    model_lo = 32'd0;
    repeat (15) @(negedge clk);
    check("rst_no_commit", {hi, lo}, 64'd0);
    check("rst_no_busy", {63'd0, busy}, 64'd0);

    // Accumulate: HI:LO = 0:FFFFFFFF then MADDU 1*1
    run_quick(4'd5, 32'd0);
    run_quick(4'd6, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
    run_multi(4'd8, 32'd1, 32'd1, 1'b1, 5);
    check("maddu_hilo", {hi, lo}, {32'd1, 32'd0});
    run_multi(4'd9, 32'hFFFFFFFE, 32'd3, 1'b0, 5);   // MSUB -2*3
    check("msub_hilo", {hi, lo}, {32'd1, 32'd6});
`else
    run_quick(4'd8, 32'd1);
    check("maddu_off_hilo", {hi, lo}, {32'd0, 32'hFFFFFFFF});
    run_quick(4'd9, 32'd1);
`endif

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
